ps2_byte_rx: RTL and testbench

Device-to-host PS/2 serial receiver. It sits directly upstream of the keyboard scan-code decoder that drives the joystick bits. It resynchronises and deglitches the raw ps2_clk and ps2_data pins, deserialises 11-bit frames, and checks start, parity and stop bits. Each good scan-code byte is presented on data with a single-cycle valid strobe. Receive-only: the host never drives the PS/2 lines from this block.

---
 rtl/ps2_byte_rx_if.sv | 10 +
 rtl/ps2_byte_rx.sv | 181 ++++++++++++++++++
 tb/tb_ps2_byte_rx.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_byte_rx_if.sv
// Receiver output bundle for ps2_byte_rx: decoded byte plus valid/error strobes and busy.
interface ps2_byte_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       error;
    logic       busy;

    modport master (output data, output valid, output error, output busy);
    modport slave  (input  data, input  valid, input  error, input  busy);
endinterface

// File: rtl/ps2_byte_rx.sv
// Device-to-host PS/2 byte receiver: pin synchronisation, clock deglitch, 11-bit frame check.
// Optional PS2_RX_TIMEOUT_EN abandons a partial frame after TIMEOUT_CYCLES idle clocks.
module ps2_byte_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    ps2_byte_rx_if.master rx
);

    if (FILTER_LEN < 2 || FILTER_LEN > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("ps2_byte_rx: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          clk_sync_q, clk_sync_d;
    logic [1:0]          data_sync_q, data_sync_d;
    logic [FILTER_LEN-1:0] filt_sh_q, filt_sh_d;
    logic                filt_q, filt_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          shreg_q, shreg_d;
    logic                parity_q, parity_d;
    logic [7:0]          data_q, data_d;
    logic                valid_q, valid_d;
    logic                error_q, error_d;
    logic                busy_q, busy_d;
    logic                fall_tick_c;
    logic                din_c;
    logic                timeout_c;

    // Two-stage synchronisers and clock deglitch shift register
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        filt_sh_d   = {filt_sh_q[FILTER_LEN-2:0], clk_sync_q[1]};
        filt_d      = filt_q;
        if (filt_sh_q == '0) begin
            filt_d = 1'b0;
        end else if (filt_sh_q == '1) begin
            filt_d = 1'b1;
        end
    end

    assign fall_tick_c = filt_q & (filt_sh_q == '0);
    assign din_c       = data_sync_q[1];

`ifdef PS2_RX_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Idle-gap counter: restarts on every edge, only runs mid-frame
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (fall_tick_c || state_q == IDLE || timeout_c) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    assign timeout_c = (state_q != IDLE) && !fall_tick_c && (to_cnt_q == TO_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (timeout_c) begin
            state_d = IDLE;
        end else if (fall_tick_c) begin
            case (state_q)
                IDLE:    state_d = din_c ? IDLE : SHIFT;
                SHIFT:   state_d = (bit_cnt_q == 3'd7) ? PARITY : SHIFT;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs and frame datapath
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        parity_d  = parity_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;
        busy_d    = (state_d != IDLE);
        if (timeout_c) begin
            error_d = 1'b1;
        end else if (fall_tick_c) begin
            case (state_q)
                IDLE: begin
                    bit_cnt_d = 3'd0;
                end
                SHIFT: begin
                    shreg_d[bit_cnt_q] = din_c;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                end
                PARITY: begin
                    parity_d = din_c;
                end
                STOP: begin
                    // Odd parity over data plus parity bit, and stop must be high
                    if (din_c && (^{shreg_q, parity_q})) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_sh_q   <= '1;
            filt_q      <= 1'b1;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 8'h00;
            parity_q    <= 1'b0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_sh_q   <= filt_sh_d;
            filt_q      <= filt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            parity_q    <= parity_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            error_q     <= error_d;
            busy_q      <= busy_d;
        end
    end

    assign rx.data  = data_q;
    assign rx.valid = valid_q;
    assign rx.error = error_q;
    assign rx.busy  = busy_q;

endmodule

// File: tb/tb_ps2_byte_rx.sv
// Scoreboard bench for ps2_byte_rx: random PS/2 frames, expected strobes queued, monitor compares.
module tb_ps2_byte_rx;
    localparam int unsigned FILTER_LEN     = 8;
    localparam int unsigned TIMEOUT_CYCLES = 1000;

    logic clk;
    logic reset;
    logic ps2_clk;
    logic ps2_data;

    ps2_byte_rx_if rx();

    ps2_byte_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx       (rx)
    );

    typedef struct {
        bit         is_err;
        logic [7:0] byte_v;
    } exp_t;

    exp_t       exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] model_data = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (required: finish before time limit)");
        $fatal(1, "watchdog");
    end

    // Monitor: every strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (reset) begin
            model_data = 8'h00;
        end else if (rx.valid || rx.error) begin
            checks++;
            if (rx.valid && rx.error) begin
                failures++;
                $display("FAIL strobe_overlap: valid=1 error=1 (required: not both)");
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe: valid=%0b error=%0b data=%02h (required: none)",
                         rx.valid, rx.error, rx.data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_err) begin
                    if (!rx.error || rx.data !== model_data) begin
                        failures++;
                        $display("FAIL error_frame: valid=%0b error=%0b data=%02h (required: error=1 data=%02h)",
                                 rx.valid, rx.error, rx.data, model_data);
                    end
                end else begin
                    if (!rx.valid || rx.data !== e.byte_v) begin
                        failures++;
                        $display("FAIL good_frame: valid=%0b error=%0b data=%02h (required: valid=1 data=%02h)",
                                 rx.valid, rx.error, rx.data, e.byte_v);
                    end
                    model_data = e.byte_v;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got=%0h required=%0h", name, got, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One PS/2 bit: data settles, clock low long enough to pass the filter, then high
    task automatic ps2_bit(input bit v);
        ps2_data = v;
        cycles(10);
        ps2_clk = 1'b0;
        cycles(20);
        ps2_clk = 1'b1;
        cycles(10);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok);
        int   ones;
        bit   par;
        exp_t e;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += b[i];
        par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        if (!par_ok) par = ~par;
        e.is_err = !(par_ok && stop_ok);
        e.byte_v = b;
        exp_q.push_back(e);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(stop_ok);
        ps2_data = 1'b1;
    endtask

    initial begin
        int busy_seen;
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        cycles(5);
        chk("reset_data",  32'(rx.data),  32'h00);
        chk("reset_valid", 32'(rx.valid), 32'h0);
        chk("reset_error", 32'(rx.error), 32'h0);
        chk("reset_busy",  32'(rx.busy),  32'h0);
        @(negedge clk);
        reset = 1'b0;
        cycles(20);

        send_frame(8'h1C, 1'b1, 1'b1);
        cycles(3);
        chk("frame_1c_data", 32'(rx.data), 32'h1C);
        chk("frame_1c_busy", 32'(rx.busy), 32'h0);

        send_frame(8'hE0, 1'b1, 1'b1);
        chk("frame_e0_data", 32'(rx.data), 32'hE0);
        send_frame(8'h75, 1'b1, 1'b1);
        chk("frame_75_data", 32'(rx.data), 32'h75);

        send_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'h29, 1'b0, 1'b1);
        cycles(3);
        chk("bad_parity_keeps_data", 32'(rx.data), 32'h1C);

        // Short clock glitch with data low must not start a frame
        ps2_data  = 1'b0;
        cycles(5);
        ps2_clk   = 1'b0;
        cycles(3);
        ps2_clk   = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (rx.busy) busy_seen = 1;
            cycles(1);
        end
        chk("glitch_no_busy", 32'(busy_seen), 32'h0);
        ps2_data = 1'b1;
        cycles(10);
        send_frame(8'h29, 1'b1, 1'b1);
        chk("after_glitch_data", 32'(rx.data), 32'h29);

`ifdef PS2_RX_TIMEOUT_EN
        begin
            exp_t e;
            e.is_err = 1'b1;
            e.byte_v = 8'h00;
            exp_q.push_back(e);
            ps2_bit(1'b0);
            for (int i = 0; i < 4; i++) ps2_bit(1'b1);
            ps2_data = 1'b1;
            cycles(TIMEOUT_CYCLES + 10);
            chk("timeout_busy", 32'(rx.busy), 32'h0);
            chk("timeout_data", 32'(rx.data), 32'h29);
            send_frame(8'h29, 1'b1, 1'b1);
            chk("after_timeout_data", 32'(rx.data), 32'h29);
        end
`endif

        // Reset after five data bits discards the partial frame
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        chk("midframe_busy", 32'(rx.busy), 32'h1);
        reset = 1'b1;
        #1;
        chk("midreset_data",  32'(rx.data),  32'h00);
        chk("midreset_valid", 32'(rx.valid), 32'h0);
        chk("midreset_busy",  32'(rx.busy),  32'h0);
        ps2_data = 1'b1;
        cycles(3);
        @(negedge clk);
        reset = 1'b0;
        cycles(20);
        send_frame(8'h75, 1'b1, 1'b1);
        chk("after_reset_data", 32'(rx.data), 32'h75);

        for (int n = 0; n < 16; n++) begin
            logic [7:0] b;
            bit par_ok;
            bit stop_ok;
            b       = 8'($urandom_range(0, 255));
            par_ok  = ($urandom_range(0, 3) != 0);
            stop_ok = ($urandom_range(0, 5) != 0);
            send_frame(b, par_ok, stop_ok);
            chk("random_busy_idle", 32'(rx.busy), 32'h0);
        end

        cycles(50);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
